// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Purpose:
//   Bit-serial sequencer that drives one shared 1-bit ALU slice (alu_1bit)
//   over WIDTH clock cycles to perform a WIDTH-bit NOT / OR / AND / ADD.
//   Operands are captured on a start handshake. One bit pair plus the
//   registered carry is presented to the slice per cycle, LSB first. The
//   slice outputs are collected into the result register, and done pulses
//   for one cycle when the operation completes.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  bit-index counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request, accepted only while ready=1
//   op          00 NOT a, 01 a OR b, 10 a AND b, 11 a+b+cin
//   a, b        operands, sampled on the accept edge (b ignored for NOT)
//   cin         carry-in, sampled on the accept edge, used only for ADD
//   ready       high only in IDLE
//   done        one-cycle pulse, result/cout valid in this cycle
//   result      final result, held until the next accept
//   cout        final carry for ADD (0 otherwise), held with result
//   slice_a/b   operand bits to the slice
//   slice_cin   registered carry to the slice
//   slice_f     function select to the slice
//   slice_out   result bit from the slice
//   slice_cout  carry from the slice
//   zero        (only with ALU_SERIAL_ZFLAG_EN) final result == 0
//
// Optional feature macro: ALU_SERIAL_ZFLAG_EN adds the registered zero flag.
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_f,
    input  logic             slice_out,
    input  logic             slice_cout
`ifdef ALU_SERIAL_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [1:0]       op_q;
    logic             cout_q;
    logic             last_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] result_nxt;

    // The slice output for the current bit enters at the MSB, so after
    // WIDTH shifts the LSB-first stream lands in natural bit order.
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign result_nxt = {slice_out, result[WIDTH-1:1]};
    // Only ADD propagates a carry; the slice may report a carry for the
    // logic ops, which must not leak into the next bit or into cout.
    assign carry_nxt  = (op_q == OP_ADD) ? slice_cout : 1'b0;
    assign cout       = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle, so a start
    // held high through DONE is seen only on the following IDLE edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the slice is only driven while bits are in flight.
    always_comb begin
        ready     = 1'b0;
        done      = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_f   = 2'b00;
        case (state)
            IDLE: ready = 1'b1;
            RUN: begin
                slice_a   = a_sh[0];
                slice_b   = b_sh[0];
                slice_cin = carry_q;
                slice_f   = op_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture on accept, one bit per RUN edge. The final
    // carry is copied into cout_q on the last RUN edge so cout survives in
    // IDLE until the next accept clears it together with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            result  <= '0;
            cout_q  <= 1'b0;
`ifdef ALU_SERIAL_ZFLAG_EN
            zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_q    <= op;
                        carry_q <= (op == OP_ADD) ? cin : 1'b0;
                        result  <= '0;
                        cnt     <= '0;
                        cout_q  <= 1'b0;
`ifdef ALU_SERIAL_ZFLAG_EN
                        zero    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result  <= result_nxt;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= carry_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout_q <= carry_nxt;
`ifdef ALU_SERIAL_ZFLAG_EN
                        zero   <= (result_nxt == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
//
// Self-checking bench for alu_serial_ctrl. Three DUTs (WIDTH = 2, 8, 16)
// share operand buses; each has its own behavioural alu_1bit slice. The
// slice reports a majority carry for every function so the controller has
// to gate carries itself. Expected {cout,result} values are pushed to a
// queue when an operation is issued and popped when done is observed.
// Define ALU_SERIAL_ZFLAG_EN to also check the zero flag.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    int          cur_w;
    logic [1:0]  op;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic        cin;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    logic start2, ready2, done2, cout2, sa2, sb2, sc2, so2, sco2;
    logic [1:0] sf2;
    logic [1:0] result2;
    logic start8, ready8, done8, cout8, sa8, sb8, sc8, so8, sco8;
    logic [1:0] sf8;
    logic [7:0] result8;
    logic start16, ready16, done16, cout16, sa16, sb16, sc16, so16, sco16;
    logic [1:0] sf16;
    logic [15:0] result16;
`ifdef ALU_SERIAL_ZFLAG_EN
    logic zero2, zero8, zero16;
`endif

    logic        done_s;
    logic        ready_s;
    logic [4:0]  slice_s;
    logic [16:0] obs_s;
    logic        zero_s;

    always #5 clk = ~clk;

    assign start2  = start & (cur_w == 2);
    assign start8  = start & (cur_w == 8);
    assign start16 = start & (cur_w == 16);

    // Behavioural alu_1bit slices (combinational).
    assign so2   = (sf2 == 2'b00) ? ~sa2 : (sf2 == 2'b01) ? (sa2 | sb2) :
                   (sf2 == 2'b10) ? (sa2 & sb2) : (sa2 ^ sb2 ^ sc2);
    assign sco2  = (sa2 & sb2) | (sa2 & sc2) | (sb2 & sc2);
    assign so8   = (sf8 == 2'b00) ? ~sa8 : (sf8 == 2'b01) ? (sa8 | sb8) :
                   (sf8 == 2'b10) ? (sa8 & sb8) : (sa8 ^ sb8 ^ sc8);
    assign sco8  = (sa8 & sb8) | (sa8 & sc8) | (sb8 & sc8);
    assign so16  = (sf16 == 2'b00) ? ~sa16 : (sf16 == 2'b01) ? (sa16 | sb16) :
                   (sf16 == 2'b10) ? (sa16 & sb16) : (sa16 ^ sb16 ^ sc16);
    assign sco16 = (sa16 & sb16) | (sa16 & sc16) | (sb16 & sc16);

    alu_serial_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op),
        .a(a_bus[1:0]), .b(b_bus[1:0]), .cin(cin),
        .ready(ready2), .done(done2), .result(result2), .cout(cout2),
        .slice_a(sa2), .slice_b(sb2), .slice_cin(sc2), .slice_f(sf2),
        .slice_out(so2), .slice_cout(sco2)
`ifdef ALU_SERIAL_ZFLAG_EN
        , .zero(zero2)
`endif
    );

    alu_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin),
        .ready(ready8), .done(done8), .result(result8), .cout(cout8),
        .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_f(sf8),
        .slice_out(so8), .slice_cout(sco8)
`ifdef ALU_SERIAL_ZFLAG_EN
        , .zero(zero8)
`endif
    );

    alu_serial_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op),
        .a(a_bus), .b(b_bus), .cin(cin),
        .ready(ready16), .done(done16), .result(result16), .cout(cout16),
        .slice_a(sa16), .slice_b(sb16), .slice_cin(sc16), .slice_f(sf16),
        .slice_out(so16), .slice_cout(sco16)
`ifdef ALU_SERIAL_ZFLAG_EN
        , .zero(zero16)
`endif
    );

    // View of the DUT currently under test.
    always_comb begin
        done_s  = done8;
        ready_s = ready8;
        slice_s = {sa8, sb8, sc8, sf8};
        obs_s   = {cout8, 8'h00, result8};
        zero_s  = 1'b0;
`ifdef ALU_SERIAL_ZFLAG_EN
        zero_s  = zero8;
`endif
        case (cur_w)
            2: begin
                done_s  = done2;
                ready_s = ready2;
                slice_s = {sa2, sb2, sc2, sf2};
                obs_s   = {cout2, 14'h0000, result2};
`ifdef ALU_SERIAL_ZFLAG_EN
                zero_s  = zero2;
`endif
            end
            16: begin
                done_s  = done16;
                ready_s = ready16;
                slice_s = {sa16, sb16, sc16, sf16};
                obs_s   = {cout16, result16};
`ifdef ALU_SERIAL_ZFLAG_EN
                zero_s  = zero16;
`endif
            end
            default: ;
        endcase
    end

    // Reference model: returns {cout, result zero-extended to 16 bits}.
    function automatic logic [16:0] ref_model(input int w, input logic [1:0] o,
                                              input logic [15:0] xa, input logic [15:0] xb,
                                              input logic xc);
        logic [16:0] mask;
        logic [16:0] am;
        logic [16:0] bm;
        logic [16:0] r;
        logic        co;
        mask = (17'd1 << w) - 17'd1;
        am   = {1'b0, xa} & mask;
        bm   = {1'b0, xb} & mask;
        co   = 1'b0;
        case (o)
            OP_NOT: r = ~am & mask;
            OP_OR:  r = am | bm;
            OP_AND: r = am & bm;
            default: begin
                r  = am + bm + {16'h0000, xc};
                co = r[w];
            end
        endcase
        r = r & mask;
        return {co, r[15:0]};
    endfunction

    // Drive one request at the selected width and leave start high after
    // the accept edge; the caller decides when to drop it.
    task automatic issue(input int w, input logic [1:0] o, input logic [15:0] xa,
                         input logic [15:0] xb, input logic xc);
        @(negedge clk);
        cur_w = w;
        #1;
        checks++;
        if (ready_s !== 1'b1 || slice_s !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_state w=%0d: ready=%b slices=%b required ready=1 slices=00000",
                     w, ready_s, slice_s);
        end
        exp_q.push_back(ref_model(w, o, xa, xb, xc));
        op    = o;
        a_bus = xa;
        b_bus = xb;
        cin   = xc;
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an accept edge: waits for done with a cycle budget,
    // checks latency, ready, the popped expectation and the hold afterwards.
    task automatic wait_done(input int w);
        int          n;
        bit          got;
        logic [16:0] exp;
        n   = 0;
        got = 0;
        while (n < w + 4) begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                got = 1;
                break;
            end
            checks++;
            if (ready_s !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ready_busy w=%0d cycle %0d: got %b required 0", w, n, ready_s);
            end
            n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL done_timeout w=%0d: no done within %0d cycles", w, w + 4);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (n != w) begin
            errors++;
            $display("[TB] FAIL done_latency w=%0d: got %0d edges required %0d", w, n, w);
        end
        checks++;
        if (ready_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_in_done w=%0d: got %b required 0", w, ready_s);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty w=%0d: done with no expected entry", w);
            return;
        end
        exp = exp_q.pop_front();
        if (obs_s !== exp) begin
            errors++;
            $display("[TB] FAIL result w=%0d: got cout,result=%h required %h", w, obs_s, exp);
        end
`ifdef ALU_SERIAL_ZFLAG_EN
        checks++;
        if (zero_s !== (exp[15:0] == 16'h0000)) begin
            errors++;
            $display("[TB] FAIL zero_flag w=%0d: got %b required %b", w, zero_s, exp[15:0] == 16'h0000);
        end
`endif
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0 || ready_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_done w=%0d: done=%b ready=%b required done=0 ready=1",
                     w, done_s, ready_s);
        end
        checks++;
        if (obs_s !== exp) begin
            errors++;
            $display("[TB] FAIL result_hold w=%0d: got %h required %h", w, obs_s, exp);
        end
    endtask

    task automatic run_op(input int w, input logic [1:0] o, input logic [15:0] xa,
                          input logic [15:0] xb, input logic xc);
        issue(w, o, xa, xb, xc);
        start = 1'b0;
        wait_done(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cur_w = 8;
        op    = 2'b00;
        a_bus = '0;
        b_bus = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: ready=%b done=%b required ready=1 done=0", ready8, done8);
        end
        checks++;
        if (result8 !== 8'h00 || cout8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_result: result=%h cout=%b required 00 0", result8, cout8);
        end
        checks++;
        if ({sa8, sb8, sc8, sf8} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_slices: got %b required 00000", {sa8, sb8, sc8, sf8});
        end
`ifdef ALU_SERIAL_ZFLAG_EN
        checks++;
        if (zero8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_zero: got %b required 0", zero8);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_op(8, OP_ADD, 16'h00A5, 16'h003C, 1'b0);
        run_op(8, OP_ADD, 16'h00FF, 16'h0000, 1'b1);
    endtask

    task automatic test_logic();
        run_op(8, OP_NOT, 16'h005A, 16'h00FF, 1'b1);
        run_op(8, OP_OR,  16'h00F0, 16'h000F, 1'b1);
        run_op(8, OP_AND, 16'h00CC, 16'h00AA, 1'b1);
    endtask

    task automatic test_start_during_run();
        issue(8, OP_ADD, 16'h0010, 16'h0020, 1'b0);
        a_bus = 16'h0001;
        b_bus = 16'h0001;
        wait_done(8);
        exp_q.push_back(ref_model(8, OP_ADD, 16'h0001, 16'h0001, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (ready_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_start_accept: ready=%b required 0", ready_s);
        end
        wait_done(8);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        issue(8, OP_ADD, 16'h005A, 16'h0033, 1'b0);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (result8 !== 8'h00 || cout8 !== 1'b0 || done8 !== 1'b0 || ready8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs: result=%h cout=%b done=%b ready=%b required 00 0 0 1",
                     result8, cout8, done8, ready8);
        end
        checks++;
        if ({sa8, sb8, sc8, sf8} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_slices: got %b required 00000", {sa8, sb8, sc8, sf8});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL midrun_no_done: got done=1 required no pulse");
        end
        run_op(8, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    endtask

    task automatic test_random(input int w);
        for (int i = 0; i < 200; i++) begin
            run_op(w, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_start_during_run();
        test_reset_mid_run();
        test_random(8);
        test_random(2);
        test_random(16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that runs one external alu_1bit slice over WIDTH clock cycles to perform a WIDTH-bit NOT/OR/AND/ADD.
- Captures operands on a start handshake and presents one bit pair plus the registered carry to the slice each cycle, LSB first.
- Collects slice outputs into a result register and pulses done.
- Sits between the operand-issuing logic and the single shared 1-bit ALU cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only while ready=1
- op  input  2  00 NOT a, 01 a OR b, 10 a AND b, 11 a+b+cin
- a  input  WIDTH  operand A, sampled on the accept edge
- b  input  WIDTH  operand B, sampled on the accept edge; ignored for NOT
- cin  input  1  carry-in, sampled on the accept edge; used only for ADD
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse; result and cout are valid in this cycle
- result  output  WIDTH  final result, held until the next accept
- cout  output  1  final carry for ADD, 0 for other ops; held with result
- slice_a  output  1  to alu_1bit a
- slice_b  output  1  to alu_1bit b
- slice_cin  output  1  to alu_1bit cin
- slice_f  output  2  to alu_1bit f
- slice_out  input  1  from alu_1bit out
- slice_cout  input  1  from alu_1bit cout

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit counter=0, operand shift registers=0, carry_q=0, op_q=0.
  - result=0, cout=0, done=0, ready=1.
  - slice_a, slice_b, slice_cin and slice_f are all 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - ready=1.
  - On a rising edge with start=1: capture a and b into shift registers and op into op_q.
  - carry_q <= (op==11) ? cin : 0. Clear result, set counter=0, go to RUN.
  - start=0 means stay in IDLE.
- RUN:
  - ready=0.
  - Slice drive (combinational): slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry_q, slice_f=op_q.
  - Each edge:
    - result <= {slice_out, result[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1.
    - carry_q <= (op_q==11) ? slice_cout : 0.
    - Counter increments.
  - On the edge where counter==WIDTH-1, go to DONE.
- DONE:
  - done=1 and ready=0; cout = carry_q.
  - The next edge goes to IDLE unconditionally.
- Latency, counting the accept edge as E0:
  - Bit i is sampled on edge E(i+1).
  - done is high in the cycle between E(WIDTH) and E(WIDTH+1).
  - ready returns to 1 after E(WIDTH+1).
- Outside RUN, all slice_* outputs are 0.
- start while ready=0 is ignored, with no queuing. This includes start held high through DONE; a held start is accepted on the first IDLE edge.
- result and cout keep their last completed values through IDLE until the next accept. On accept, result is cleared.
- ADD overflow is reported only via cout; no sign or overflow logic.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, no done pulse, operation discarded.
- Slice inputs are treated as combinational in the same cycle; no extra pipeline stage.

Optional Feature:
- Macro ALU_SERIAL_ZFLAG_EN.
- Defined:
  - Adds output port zero (1 bit), reset 0.
  - zero is registered on the DONE-entry edge as (final result == 0).
  - It is valid alongside done and held with result until the next accept; the accept edge clears it to 0.
- Undefined: zero port and its logic are absent; all other behaviour is identical.

Test Plan:
- ADD, a=8'hA5, b=8'h3C, cin=0 -> result=8'hE1, cout=0.
  - done rises exactly 8 edges after the accept edge and lasts 1 cycle.
  - ready=0 from accept until after DONE.
- ADD, a=8'hFF, b=8'h00, cin=1 -> result=8'h00, cout=1; zero=1 when ALU_SERIAL_ZFLAG_EN is defined.
- Logic ops:
  - NOT a=8'h5A -> 8'hA5, cout=0.
  - OR 8'hF0|8'h0F -> 8'hFF.
  - AND 8'hCC&8'hAA -> 8'h88.
  - Each with cin=1 -> cout stays 0.
- Start during RUN with a=8'h01, b=8'h01 while computing 8'h10+8'h20 -> ignored; result=8'h30.
  - start held high through DONE -> accepted on the next IDLE edge with the new operands.
- rst_n pulsed low after bit 3 of an ADD -> all outputs 0 immediately, done never pulses.
  - The next ADD 8'h01+8'h01 -> 8'h02.
- 200 random op/a/b/cin vectors with a behavioural reference model, also at WIDTH=2 and WIDTH=16 -> {cout,result} match every done.
  - slice_* outputs stay 0 in IDLE.
